// File: rtl/sdrc_req_arbiter.sv
// rtl/sdrc_req_arbiter.sv - two-port round-robin arbiter and sequencer for the SDRAM controller app interface
//
// Ports:
//   clk, reset                  controller clock, asynchronous active-high reset
//   pN_req/addr/len/wr_n/ack    port N request phase (N = 0, 1)
//   pN_wr_data/wr_en_n/wr_next  port N write data path
//   pN_rd_data/rd_valid         port N read data path
//   app_req*/app_req_ack        request phase towards the controller
//   app_wr_*/app_last_wr        write data path towards the controller
//   app_rd_*/app_last_rd        read data path from the controller
//   gnt, busy, len_err          one-hot grant, not-idle flag, sticky burst length error
module sdrc_req_arbiter #(
  parameter int APP_AW = 26,
  parameter int APP_DW = 32,
  parameter int BL_W   = 9,
  localparam int APP_BW = APP_DW / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic [APP_AW-1:0] p0_req_addr,
  input  logic [BL_W-1:0]   p0_req_len,
  input  logic              p0_req_wr_n,
  output logic              p0_req_ack,
  input  logic [APP_DW-1:0] p0_wr_data,
  input  logic [APP_BW-1:0] p0_wr_en_n,
  output logic              p0_wr_next,
  output logic [APP_DW-1:0] p0_rd_data,
  output logic              p0_rd_valid,
  input  logic              p1_req,
  input  logic [APP_AW-1:0] p1_req_addr,
  input  logic [BL_W-1:0]   p1_req_len,
  input  logic              p1_req_wr_n,
  output logic              p1_req_ack,
  input  logic [APP_DW-1:0] p1_wr_data,
  input  logic [APP_BW-1:0] p1_wr_en_n,
  output logic              p1_wr_next,
  output logic [APP_DW-1:0] p1_rd_data,
  output logic              p1_rd_valid,
  output logic              app_req,
  output logic [APP_AW-1:0] app_req_addr,
  output logic [BL_W-1:0]   app_req_len,
  output logic              app_req_wr_n,
  input  logic              app_req_ack,
  output logic [APP_DW-1:0] app_wr_data,
  output logic [APP_BW-1:0] app_wr_en_n,
  input  logic              app_wr_next,
  input  logic              app_last_wr,
  input  logic [APP_DW-1:0] app_rd_data,
  input  logic              app_rd_valid,
  input  logic              app_last_rd,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              len_err
);

  typedef enum logic [1:0] {IDLE, REQ, XFR} state_t;

  state_t          state;
  logic            rr_last;   // index of the port granted most recently
  logic [1:0]      zl_ack;    // ack pulse for a zero-length request
  logic [BL_W-1:0] beat_cnt;

  logic            any_req;
  logic            win;       // 1 selects port 1
  logic [BL_W-1:0] win_len;
  logic            xfr, xfr_wr, xfr_rd;
  logic            beat, last_beat;
  logic [BL_W-1:0] beat_nxt;

  // Arbitration is held off while a zero-length ack is on the wire: the
  // requester still holds req in that cycle and would otherwise be accepted twice.
  assign any_req = (p0_req | p1_req) & ~|zl_ack;
  assign win     = (p0_req & p1_req) ? ~rr_last : p1_req;
  assign win_len = win ? p1_req_len : p0_req_len;

  assign xfr       = (state == XFR);
  assign xfr_wr    = xfr & ~app_req_wr_n;
  assign xfr_rd    = xfr & app_req_wr_n;
  assign beat      = app_req_wr_n ? app_rd_valid : app_wr_next;
  assign last_beat = app_req_wr_n ? app_last_rd : app_last_wr;
  assign beat_nxt  = beat_cnt + BL_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rr_last      <= 1'b1;
      zl_ack       <= 2'b00;
      gnt          <= 2'b00;
      app_req      <= 1'b0;
      app_req_addr <= '0;
      app_req_len  <= '0;
      app_req_wr_n <= 1'b0;
      beat_cnt     <= '0;
      len_err      <= 1'b0;
    end else begin
      zl_ack <= 2'b00;
      case (state)
        IDLE: begin
          if (any_req) begin
            rr_last <= win;
            if (win_len == '0) begin
              zl_ack <= {win, ~win};
            end else begin
              app_req      <= 1'b1;
              app_req_addr <= win ? p1_req_addr : p0_req_addr;
              app_req_len  <= win_len;
              app_req_wr_n <= win ? p1_req_wr_n : p0_req_wr_n;
              gnt          <= {win, ~win};
              state        <= REQ;
            end
          end
        end
        REQ: begin
          if (app_req_ack) begin
            app_req  <= 1'b0;
            beat_cnt <= '0;
            state    <= XFR;
          end
        end
        XFR: begin
          if (beat) begin
            beat_cnt <= beat_nxt;
            if (last_beat) begin
              if (beat_nxt != app_req_len) len_err <= 1'b1;
              gnt   <= 2'b00;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign p0_req_ack = ((state == REQ) & gnt[0] & app_req_ack) | zl_ack[0];
  assign p1_req_ack = ((state == REQ) & gnt[1] & app_req_ack) | zl_ack[1];

  // gnt is one-hot whenever state is XFR, so gnt[1] alone selects the port.
  assign app_wr_data = xfr ? (gnt[1] ? p1_wr_data : p0_wr_data) : '0;
  assign app_wr_en_n = xfr ? (gnt[1] ? p1_wr_en_n : p0_wr_en_n) : '1;

  assign p0_wr_next  = xfr_wr & gnt[0] & app_wr_next;
  assign p1_wr_next  = xfr_wr & gnt[1] & app_wr_next;
  assign p0_rd_valid = xfr_rd & gnt[0] & app_rd_valid;
  assign p1_rd_valid = xfr_rd & gnt[1] & app_rd_valid;
  assign p0_rd_data  = app_rd_data;
  assign p1_rd_data  = app_rd_data;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sdrc_req_arbiter.sv
// tb/tb_sdrc_req_arbiter.sv - directed self-checking bench for sdrc_req_arbiter
module tb_sdrc_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p1_req;
  logic [25:0] p0_req_addr, p1_req_addr;
  logic [8:0]  p0_req_len, p1_req_len;
  logic        p0_req_wr_n, p1_req_wr_n;
  logic        p0_req_ack, p1_req_ack;
  logic [31:0] p0_wr_data, p1_wr_data;
  logic [3:0]  p0_wr_en_n, p1_wr_en_n;
  logic        p0_wr_next, p1_wr_next;
  logic [31:0] p0_rd_data, p1_rd_data;
  logic        p0_rd_valid, p1_rd_valid;
  logic        app_req;
  logic [25:0] app_req_addr;
  logic [8:0]  app_req_len;
  logic        app_req_wr_n;
  logic        app_req_ack;
  logic [31:0] app_wr_data;
  logic [3:0]  app_wr_en_n;
  logic        app_wr_next, app_last_wr;
  logic [31:0] app_rd_data;
  logic        app_rd_valid, app_last_rd;
  logic [1:0]  gnt;
  logic        busy, len_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_len_err;

  sdrc_req_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_req_addr(p0_req_addr), .p0_req_len(p0_req_len),
    .p0_req_wr_n(p0_req_wr_n), .p0_req_ack(p0_req_ack),
    .p0_wr_data(p0_wr_data), .p0_wr_en_n(p0_wr_en_n), .p0_wr_next(p0_wr_next),
    .p0_rd_data(p0_rd_data), .p0_rd_valid(p0_rd_valid),
    .p1_req(p1_req), .p1_req_addr(p1_req_addr), .p1_req_len(p1_req_len),
    .p1_req_wr_n(p1_req_wr_n), .p1_req_ack(p1_req_ack),
    .p1_wr_data(p1_wr_data), .p1_wr_en_n(p1_wr_en_n), .p1_wr_next(p1_wr_next),
    .p1_rd_data(p1_rd_data), .p1_rd_valid(p1_rd_valid),
    .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
    .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack),
    .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
    .app_wr_next(app_wr_next), .app_last_wr(app_last_wr),
    .app_rd_data(app_rd_data), .app_rd_valid(app_rd_valid), .app_last_rd(app_last_rd),
    .gnt(gnt), .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    app_req_ack  = 1'b0;
    app_wr_next  = 1'b0;
    app_last_wr  = 1'b0;
    app_rd_valid = 1'b0;
    app_last_rd  = 1'b0;
  endtask

  // One complete transaction from IDLE. mask: requesting ports; wp: expected winner.
  task automatic txn(input logic [1:0] mask, input int wp, input logic wr_n,
                     input logic [8:0] len, input int beats, input string tag);
    logic [31:0] wd;
    logic [3:0]  we;
    p0_req = mask[0]; p0_req_addr = 26'h100; p0_req_len = len; p0_req_wr_n = wr_n;
    p1_req = mask[1]; p1_req_addr = 26'h200; p1_req_len = len; p1_req_wr_n = wr_n;
    #1;
    check({tag, "/idle_app_req"}, app_req, 0);
    cyc();
    check({tag, "/app_req"}, app_req, 1);
    check({tag, "/gnt"}, gnt, (wp == 1) ? 2'b10 : 2'b01);
    check({tag, "/addr"}, app_req_addr, (wp == 1) ? 26'h200 : 26'h100);
    check({tag, "/len"}, app_req_len, len);
    check({tag, "/wr_n"}, app_req_wr_n, wr_n);
    check({tag, "/busy"}, busy, 1);
    cyc();
    check({tag, "/app_req_hold"}, app_req, 1);
    check({tag, "/no_ack_early"}, {p1_req_ack, p0_req_ack}, 2'b00);
    app_req_ack = 1'b1;
    #1;
    check({tag, "/req_ack"}, {p1_req_ack, p0_req_ack}, (wp == 1) ? 2'b10 : 2'b01);
    cyc();
    app_req_ack = 1'b0;
    if (wp == 1) p1_req = 1'b0; else p0_req = 1'b0;
    #1;
    check({tag, "/app_req_drop"}, app_req, 0);
    check({tag, "/ack_after"}, {p1_req_ack, p0_req_ack}, 2'b00);
    for (int i = 0; i < beats; i++) begin
      if (!wr_n) begin
        p0_wr_data = 32'hA000_0000 + i; p0_wr_en_n = 4'h0;
        p1_wr_data = 32'hB000_0000 + i; p1_wr_en_n = 4'hA;
        app_wr_next = 1'b1; app_last_wr = (i == beats - 1);
        wd = (wp == 1) ? 32'hB000_0000 + i : 32'hA000_0000 + i;
        we = (wp == 1) ? 4'hA : 4'h0;
        #1;
        check($sformatf("%s/wdata%0d", tag, i), app_wr_data, wd);
        check($sformatf("%s/wen%0d", tag, i), app_wr_en_n, we);
        check($sformatf("%s/wr_next%0d", tag, i), {p1_wr_next, p0_wr_next},
              (wp == 1) ? 2'b10 : 2'b01);
      end else begin
        app_rd_data = 32'hC000_0000 + i; app_rd_valid = 1'b1; app_last_rd = (i == beats - 1);
        #1;
        check($sformatf("%s/rdata%0d", tag, i), (wp == 1) ? p1_rd_data : p0_rd_data,
              32'hC000_0000 + i);
        check($sformatf("%s/rd_valid%0d", tag, i), {p1_rd_valid, p0_rd_valid},
              (wp == 1) ? 2'b10 : 2'b01);
      end
      check($sformatf("%s/busy%0d", tag, i), busy, 1);
      cyc();
    end
    clear_strobes();
    #1;
    check({tag, "/busy_end"}, busy, 0);
    check({tag, "/gnt_end"}, gnt, 2'b00);
    check({tag, "/len_err"}, len_err, exp_len_err);
  endtask

  initial begin
    reset = 1'b1;
    p0_req = 0; p0_req_addr = 0; p0_req_len = 0; p0_req_wr_n = 0;
    p1_req = 0; p1_req_addr = 0; p1_req_len = 0; p1_req_wr_n = 0;
    p0_wr_data = 0; p0_wr_en_n = 4'hF; p1_wr_data = 0; p1_wr_en_n = 4'hF;
    app_rd_data = 0;
    clear_strobes();
    exp_len_err = 1'b0;
    repeat (3) cyc();
    check("rst/gnt", gnt, 2'b00);
    check("rst/busy", busy, 0);
    check("rst/app_req", app_req, 0);
    check("rst/len_err", len_err, 0);
    check("rst/wen", app_wr_en_n, 4'hF);
    check("rst/wdata", app_wr_data, 32'h0);
    reset = 1'b0;
    cyc();

    // p0 write, len 4
    txn(2'b01, 0, 1'b0, 9'd4, 4, "p0_wr");

    // strobes while idle are ignored
    app_wr_next = 1'b1; app_rd_valid = 1'b1;
    #1;
    check("idle_strobe/wr_next", {p1_wr_next, p0_wr_next}, 2'b00);
    check("idle_strobe/rd_valid", {p1_rd_valid, p0_rd_valid}, 2'b00);
    clear_strobes();
    cyc();

    // p1 read, len 8
    txn(2'b10, 1, 1'b1, 9'd8, 8, "p1_rd");

    // both request, three times: p0, p1, p0
    txn(2'b11, 0, 1'b0, 9'd2, 2, "rr0");
    txn(2'b11, 1, 1'b0, 9'd2, 2, "rr1");
    txn(2'b11, 0, 1'b1, 9'd2, 2, "rr2");
    p1_req = 1'b0;
    cyc();

    // short burst: len 4, last on beat 3
    exp_len_err = 1'b1;
    txn(2'b10, 1, 1'b1, 9'd4, 3, "short");
    txn(2'b01, 0, 1'b0, 9'd3, 3, "sticky");

    // zero-length request on p0
    p0_req = 1'b1; p0_req_len = 9'd0; p0_req_wr_n = 1'b0;
    cyc();
    check("zl/ack", {p1_req_ack, p0_req_ack}, 2'b01);
    check("zl/app_req", app_req, 0);
    check("zl/busy", busy, 0);
    cyc();
    p0_req = 1'b0;
    #1;
    check("zl/ack_once", {p1_req_ack, p0_req_ack}, 2'b00);
    check("zl/app_req2", app_req, 0);
    txn(2'b11, 1, 1'b0, 9'd1, 1, "after_zl");
    p0_req = 1'b0;
    cyc();

    // reset during beat 2 of a 4-beat read
    p0_req = 1'b1; p0_req_addr = 26'h100; p0_req_len = 9'd4; p0_req_wr_n = 1'b1;
    cyc();
    app_req_ack = 1'b1;
    cyc();
    app_req_ack = 1'b0; p0_req = 1'b0;
    app_rd_valid = 1'b1; app_rd_data = 32'h1;
    cyc();
    app_rd_data = 32'h2;
    #1;
    check("mid/rd_valid_pre", p0_rd_valid, 1);
    reset = 1'b1;
    #1;
    check("mid/app_req", app_req, 0);
    check("mid/gnt", gnt, 2'b00);
    check("mid/busy", busy, 0);
    check("mid/len_err", len_err, 0);
    check("mid/rd_valid", p0_rd_valid, 0);
    clear_strobes();
    cyc();
    reset = 1'b0;
    exp_len_err = 1'b0;
    cyc();
    txn(2'b01, 0, 1'b0, 9'd4, 4, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
